dac_wave_gen: RTL

- Upstream sample source for the PLB DAC user logic; generates a 10-bit waveform sample stream at a programmable rate from bus-written configuration.
- Phase accumulator plus divider tick; waveform selectable as DC, sawtooth, triangle or square.
- Samples are handed downstream over a valid/ready handshake; the DAC-side logic consumes them and drives the converter pins.
- Dropped samples under backpressure are counted for software readback.

---
 rtl/dac_wave_gen_if.sv | 11 +
 rtl/dac_wave_gen.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/dac_wave_gen_if.sv
// Sample handshake between dac_wave_gen (master) and the DAC-side logic (slave).
interface dac_wave_gen_if #(
  parameter int DATA_W = 10
);
  logic [DATA_W-1:0] Smp_Data;
  logic              Smp_Valid;
  logic              Smp_Ready;

  modport master (output Smp_Data, output Smp_Valid, input Smp_Ready);
  modport slave  (input Smp_Data, input Smp_Valid, output Smp_Ready);
endinterface

// File: rtl/dac_wave_gen.sv
// Waveform sample source: phase accumulator, divider tick, valid/ready output, slip counter.
// Define DAC_WAVE_SINE_EN to add wave code 4 (quarter-wave sine table); otherwise code 4 is reserved.
module dac_wave_gen #(
  parameter int DATA_W = 10,
  parameter int DIV_W  = 16,
  parameter int SLIP_W = 8
) (
  input  logic                Bus2IP_Clk,
  input  logic                Bus2IP_Reset,
  input  logic                Cfg_Enable,
  input  logic [2:0]          Cfg_Wave,
  input  logic [DIV_W-1:0]    Cfg_Div,
  input  logic [DATA_W-1:0]   Cfg_Step,
  input  logic [DATA_W-1:0]   Cfg_Const,
  input  logic                Slip_Clr,
  dac_wave_gen_if.master      smp,
  output logic                Busy,
  output logic [SLIP_W-1:0]   Slip_Cnt
);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_e;

  localparam logic [2:0] WAVE_DC   = 3'd0;
  localparam logic [2:0] WAVE_SAW  = 3'd1;
  localparam logic [2:0] WAVE_TRI  = 3'd2;
  localparam logic [2:0] WAVE_SQR  = 3'd3;
  localparam logic [DATA_W-1:0] MIDSCALE = DATA_W'(512);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   phase_q, phase_d;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [DATA_W-1:0]   smp_data_q, smp_data_d;
  logic                smp_valid_q, smp_valid_d;
  logic [SLIP_W-1:0]   slip_cnt_q, slip_cnt_d;

  logic [DIV_W-1:0]    div_eff;
  logic                tick;
  logic [DATA_W-1:0]   sample;

`ifdef DAC_WAVE_SINE_EN
  // Elaboration-time table: q[k] = round(511*sin(2*pi*(k+0.5)/1024)), packed 9 bits per entry.
  function automatic logic [256*9-1:0] build_sine_tab();
    logic [256*9-1:0] tab;
    real              a;
    tab = '0;
    for (int k = 0; k < 256; k++) begin
      a = 511.0 * $sin(2.0 * 3.14159265358979 * (real'(k) + 0.5) / 1024.0);
      tab[k*9 +: 9] = 9'($rtoi(a + 0.5));
    end
    return tab;
  endfunction

  localparam logic [256*9-1:0] SINE_Q = build_sine_tab();

  logic [7:0] sine_idx;
  logic [8:0] sine_q;

  always_comb begin
    sine_idx = phase_q[8] ? ~phase_q[7:0] : phase_q[7:0];
    sine_q   = SINE_Q[sine_idx*9 +: 9];
  end
`endif

  always_comb begin
    sample = MIDSCALE;
    case (Cfg_Wave)
      WAVE_DC:  sample = Cfg_Const;
      WAVE_SAW: sample = phase_q;
      WAVE_TRI: sample = phase_q[9] ? {~phase_q[8:0], 1'b0} : {phase_q[8:0], 1'b0};
      WAVE_SQR: sample = phase_q[9] ? '0 : '1;
`ifdef DAC_WAVE_SINE_EN
      3'd4:     sample = phase_q[9] ? (10'd511 - {1'b0, sine_q}) : (10'd512 + {1'b0, sine_q});
`endif
      default:  sample = MIDSCALE;
    endcase
  end

  // A divider of 0 behaves as 1; >= keeps a shrinking divider from overrunning.
  assign div_eff = (Cfg_Div == '0) ? DIV_W'(1) : Cfg_Div;
  assign tick    = (state_q == S_RUN) && Cfg_Enable && (div_cnt_q >= div_eff - DIV_W'(1));

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through this block can infer a latch.
    state_d     = state_q;
    phase_d     = phase_q;
    div_cnt_d   = div_cnt_q;
    smp_data_d  = smp_data_q;
    smp_valid_d = smp_valid_q;
    slip_cnt_d  = slip_cnt_q;

    if (smp_valid_q && smp.Smp_Ready) smp_valid_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (Cfg_Enable) begin
          state_d   = S_RUN;
          phase_d   = '0;
          div_cnt_d = '0;
        end
      end
      S_RUN: begin
        if (!Cfg_Enable) begin
          state_d     = S_IDLE;
          smp_valid_d = 1'b0;
          phase_d     = '0;
          div_cnt_d   = '0;
        end else if (tick) begin
          div_cnt_d = '0;
          phase_d   = phase_q + Cfg_Step;
          if (!smp_valid_q || smp.Smp_Ready) begin
            smp_data_d  = sample;
            smp_valid_d = 1'b1;
          end else begin
            smp_valid_d = 1'b1;
            if (slip_cnt_q != '1) slip_cnt_d = slip_cnt_q + SLIP_W'(1);
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (Slip_Clr) slip_cnt_d = '0;
  end

  // NOTE: state registers use non-blocking assignment so all flops update together on the edge.
  always_ff @(posedge Bus2IP_Clk) begin
    if (Bus2IP_Reset) begin
      state_q     <= S_IDLE;
      phase_q     <= '0;
      div_cnt_q   <= '0;
      smp_data_q  <= '0;
      smp_valid_q <= 1'b0;
      slip_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      div_cnt_q   <= div_cnt_d;
      smp_data_q  <= smp_data_d;
      smp_valid_q <= smp_valid_d;
      slip_cnt_q  <= slip_cnt_d;
    end
  end

  assign smp.Smp_Data  = smp_data_q;
  assign smp.Smp_Valid = smp_valid_q;
  assign Busy          = (state_q == S_RUN);
  assign Slip_Cnt      = slip_cnt_q;

endmodule
